idma_eh_responder: RTL and testbench

Frontend-side error-handling responder for the iDMA backend. It accepts error reports from a backend built with `ERROR_HANDLING`, logs them in a small FIFO that software reads, and decides each one. The decision is either automatic by policy or taken from software. It returns that decision to the backend as an `idma_eh_req_t` (`CONTINUE`/`ABORT`) over a valid/ready handshake. It drives the backend's `eh_fsm_busy` field and holds a saturating error count.

---
 rtl/idma_eh_responder_if.sv | 40 ++++
 rtl/idma_eh_responder.sv | 101 ++++++++++
 tb/tb_idma_eh_responder.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/idma_eh_responder_if.sv
// Signal bundle between the iDMA backend/software side and the error-handling responder.
// Signal names match the responder's documented port list.
interface idma_eh_responder_if #(
  parameter int AddrWidth = 32,
  parameter int CntWidth  = 8
);
  logic                 err_valid_i;
  logic                 err_ready_o;
  logic [1:0]           err_type_i;
  logic [AddrWidth-1:0] err_addr_i;
  logic                 eh_valid_o;
  logic                 eh_ready_i;
  logic                 eh_o;
  logic                 auto_i;
  logic                 auto_action_i;
  logic                 sw_valid_i;
  logic                 sw_action_i;
  logic                 sw_ready_o;
  logic                 log_valid_o;
  logic [1:0]           log_type_o;
  logic [AddrWidth-1:0] log_addr_o;
  logic                 log_pop_i;
  logic                 overflow_o;
  logic [CntWidth-1:0]  err_count_o;
  logic                 busy_o;

  modport slave (
    input  err_valid_i, err_type_i, err_addr_i, eh_ready_i, auto_i, auto_action_i,
           sw_valid_i, sw_action_i, log_pop_i,
    output err_ready_o, eh_valid_o, eh_o, sw_ready_o, log_valid_o, log_type_o,
           log_addr_o, overflow_o, err_count_o, busy_o
  );

  modport master (
    output err_valid_i, err_type_i, err_addr_i, eh_ready_i, auto_i, auto_action_i,
           sw_valid_i, sw_action_i, log_pop_i,
    input  err_ready_o, eh_valid_o, eh_o, sw_ready_o, log_valid_o, log_type_o,
           log_addr_o, overflow_o, err_count_o, busy_o
  );
endinterface

// File: rtl/idma_eh_responder.sv
// Error-handling responder: logs backend error reports, decides CONTINUE/ABORT
// (by policy or software) and hands the decision back over valid/ready.
module idma_eh_responder #(
  parameter int AddrWidth = 32,
  parameter int FifoDepth = 4,
  parameter int CntWidth  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  idma_eh_responder_if.slave   eh
);
  localparam int PtrW = $clog2(FifoDepth);
  localparam logic [PtrW:0] Depth = (PtrW+1)'(FifoDepth);
  localparam logic [1:0] TypeBackend = 2'd2;

  typedef enum logic [1:0] {IDLE, WAIT_SW, RESPOND} state_e;

  state_e state_q, state_d;
  logic   act_q, act_d;
  logic   accept, pop, push_en;

  logic [FifoDepth-1:0][1:0]           type_mem;
  logic [FifoDepth-1:0][AddrWidth-1:0] addr_mem;
  logic [PtrW-1:0] wptr, rptr;
  logic [PtrW:0]   fill;
  logic            empty, full;
  logic            overflow_q;
  logic [CntWidth-1:0] count_q;

  assign accept  = (state_q == IDLE) && eh.err_valid_i;
  assign empty   = (fill == '0);
  assign full    = (fill == Depth);
  assign pop     = eh.log_pop_i && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_en = accept && (!full || pop);

  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    unique case (state_q)
      IDLE: if (eh.err_valid_i) begin
        if (eh.auto_i) begin
          act_d   = (eh.err_type_i == TypeBackend) ? 1'b1 : eh.auto_action_i;
          state_d = RESPOND;
        end else begin
          state_d = WAIT_SW;
        end
      end
      WAIT_SW: if (eh.sw_valid_i) begin
        act_d   = eh.sw_action_i;
        state_d = RESPOND;
      end
      RESPOND: if (eh.eh_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      act_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      type_mem   <= '0;
      addr_mem   <= '0;
      wptr       <= '0;
      rptr       <= '0;
      fill       <= '0;
      overflow_q <= 1'b0;
      count_q    <= '0;
    end else begin
      if (push_en) begin
        type_mem[wptr] <= eh.err_type_i;
        addr_mem[wptr] <= eh.err_addr_i;
        wptr           <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      if (push_en && !pop)      fill <= fill + 1'b1;
      else if (pop && !push_en) fill <= fill - 1'b1;
      if (accept && !push_en) overflow_q <= 1'b1;
      if (accept && (count_q != '1)) count_q <= count_q + 1'b1;
    end
  end

  assign eh.err_ready_o = (state_q == IDLE);
  assign eh.sw_ready_o  = (state_q == WAIT_SW);
  assign eh.eh_valid_o  = (state_q == RESPOND);
  assign eh.eh_o        = (state_q == RESPOND) && act_q;
  assign eh.busy_o      = (state_q != IDLE);
  assign eh.log_valid_o = !empty;
  assign eh.log_type_o  = empty ? 2'b0 : type_mem[rptr];
  assign eh.log_addr_o  = empty ? '0 : addr_mem[rptr];
  assign eh.overflow_o  = overflow_q;
  assign eh.err_count_o = count_q;
endmodule

// File: tb/tb_idma_eh_responder.sv
// Randomized + directed bench for idma_eh_responder against a transaction-level model.
module tb_idma_eh_responder;
  localparam int AW = 32;
  localparam int FD = 4;
  localparam int CW = 2;

  logic clk_i = 1'b0;
  logic rst_ni;
  int   n_chk = 0;
  int   n_err = 0;

  idma_eh_responder_if #(.AddrWidth(AW), .CntWidth(CW)) bus ();

  idma_eh_responder #(.AddrWidth(AW), .FifoDepth(FD), .CntWidth(CW)) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .eh    (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [1:0] t; logic [AW-1:0] a; } ent_t;
  ent_t q[$];
  bit   m_pending, m_decided, m_dec, m_ovf;
  int   m_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_pending = 0; m_decided = 0; m_dec = 0; m_ovf = 0; m_cnt = 0;
  endfunction

  // Advance the model by one clock using the inputs present at the edge.
  function automatic void model_step();
    bit acc, pp;
    acc = !m_pending && bus.err_valid_i;
    pp  = bus.log_pop_i && (q.size() > 0);
    if (pp) void'(q.pop_front());
    if (acc) begin
      if (q.size() < FD) q.push_back('{bus.err_type_i, bus.err_addr_i});
      else m_ovf = 1;
      if (m_cnt < (1 << CW) - 1) m_cnt++;
      m_pending = 1;
      m_decided = bus.auto_i;
      if (bus.auto_i) m_dec = (bus.err_type_i == 2'd2) ? 1'b1 : bus.auto_action_i;
    end else if (m_pending && !m_decided && bus.sw_valid_i) begin
      m_decided = 1;
      m_dec     = bus.sw_action_i;
    end else if (m_pending && m_decided && bus.eh_ready_i) begin
      m_pending = 0;
      m_decided = 0;
    end
  endfunction

  task automatic compare_all();
    chk("err_ready", bus.err_ready_o, !m_pending);
    chk("sw_ready",  bus.sw_ready_o,  m_pending && !m_decided);
    chk("eh_valid",  bus.eh_valid_o,  m_pending && m_decided);
    chk("eh",        bus.eh_o,        m_pending && m_decided && m_dec);
    chk("busy",      bus.busy_o,      m_pending);
    chk("log_valid", bus.log_valid_o, q.size() > 0);
    chk("log_type",  bus.log_type_o,  q.size() > 0 ? q[0].t : 2'd0);
    chk("log_addr",  bus.log_addr_o,  q.size() > 0 ? q[0].a : '0);
    chk("overflow",  bus.overflow_o,  m_ovf);
    chk("count",     bus.err_count_o, m_cnt);
  endtask

  task automatic step();
    @(posedge clk_i);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    bus.err_valid_i = 0; bus.err_type_i = 0; bus.err_addr_i = '0;
    bus.eh_ready_i = 0; bus.auto_i = 0; bus.auto_action_i = 0;
    bus.sw_valid_i = 0; bus.sw_action_i = 0; bus.log_pop_i = 0;
  endtask

  task automatic do_reset();
    rst_ni = 0;
    #1;
    model_reset();
    chk("rst_err_ready", bus.err_ready_o, 1);
    chk("rst_eh_valid",  bus.eh_valid_o, 0);
    chk("rst_busy",      bus.busy_o, 0);
    chk("rst_count",     bus.err_count_o, 0);
    chk("rst_log_valid", bus.log_valid_o, 0);
    compare_all();
    @(negedge clk_i);
    rst_ni = 1;
  endtask

  initial begin
    idle_inputs();
    rst_ni = 1;
    #2;
    do_reset();

    // auto continue
    bus.auto_i = 1; bus.auto_action_i = 0;
    bus.err_valid_i = 1; bus.err_type_i = 2'd0; bus.err_addr_i = 32'h1000;
    step();
    bus.err_valid_i = 0;
    chk("ac_eh_valid", bus.eh_valid_o, 1);
    chk("ac_eh",       bus.eh_o, 0);
    chk("ac_log_addr", bus.log_addr_o, 32'h1000);
    chk("ac_count",    bus.err_count_o, 1);
    bus.eh_ready_i = 1; bus.log_pop_i = 1;
    step();
    bus.eh_ready_i = 0; bus.log_pop_i = 0;

    // BACKEND overrides auto CONTINUE
    bus.err_valid_i = 1; bus.err_type_i = 2'd2; bus.err_addr_i = 32'h2000;
    step();
    bus.err_valid_i = 0;
    chk("be_eh", bus.eh_o, 1);
    bus.eh_ready_i = 1; bus.log_pop_i = 1;
    step();
    bus.eh_ready_i = 0; bus.log_pop_i = 0;

    // manual flow
    bus.auto_i = 0;
    bus.err_valid_i = 1; bus.err_type_i = 2'd1; bus.err_addr_i = 32'h3000;
    step();
    bus.err_valid_i = 0;
    chk("man_sw_ready", bus.sw_ready_o, 1);
    for (int i = 0; i < 5; i++) begin
      bus.auto_i = i[0];
      step();
      chk("man_hold_eh_valid", bus.eh_valid_o, 0);
      chk("man_hold_err_ready", bus.err_ready_o, 0);
    end
    bus.sw_valid_i = 1; bus.sw_action_i = 1;
    step();
    bus.sw_valid_i = 0; bus.sw_action_i = 0;
    chk("man_eh_valid", bus.eh_valid_o, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("man_eh_stable", bus.eh_o, 1);
    end
    bus.eh_ready_i = 1;
    step();
    bus.eh_ready_i = 0;
    chk("man_err_ready", bus.err_ready_o, 1);

    // overflow and counter saturation from a clean start
    do_reset();
    bus.auto_i = 1; bus.eh_ready_i = 1;
    for (int i = 0; i < 5; i++) begin
      bus.err_valid_i = 1; bus.err_addr_i = 32'h100 * (i + 1); bus.err_type_i = 2'(i);
      step();
      bus.err_valid_i = 0;
      chk("sat_count", bus.err_count_o, (i < 3) ? i + 1 : 3);
      step();
    end
    chk("ovf_flag", bus.overflow_o, 1);
    chk("ovf_head", bus.log_addr_o, 32'h100);
    bus.eh_ready_i = 0;
    bus.log_pop_i = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i < 3) chk("pop_head", bus.log_addr_o, 32'h100 * (i + 2));
      else chk("pop_empty", bus.log_valid_o, 0);
    end
    bus.log_pop_i = 0;

    // async reset while responding
    bus.err_valid_i = 1; bus.eh_ready_i = 0;
    step();
    bus.err_valid_i = 0;
    chk("pre_rst_eh_valid", bus.eh_valid_o, 1);
    #2;
    do_reset();

    // randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      bus.err_valid_i   = ($urandom_range(0, 2) != 0);
      bus.err_type_i    = 2'($urandom);
      bus.err_addr_i    = $urandom;
      bus.eh_ready_i    = ($urandom_range(0, 2) == 0);
      bus.auto_i        = $urandom_range(0, 1);
      bus.auto_action_i = $urandom_range(0, 1);
      bus.sw_valid_i    = ($urandom_range(0, 3) == 0);
      bus.sw_action_i   = $urandom_range(0, 1);
      bus.log_pop_i     = ($urandom_range(0, 3) == 0);
      step();
      if ($urandom_range(0, 299) == 0) begin
        #2;
        do_reset();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
